i2s_audio_streamer: RTL
=======================

I2S_AUDIO_STREAMER -- requirements
Module: i2s_audio_streamer

Interface
REQ-001 Parameter SAMPLE_W, default 16: bits per channel sample (8..32).
REQ-002 Parameter SLOT_W, default 32: BCLK periods per channel slot; SLOT_W > SAMPLE_W.
REQ-003 Parameter CHANNELS, default 2: 1 = mono, 2 = stereo.
REQ-004 Parameter BCLK_DIV, default 4: clk cycles per BCLK half-period (>= 1).
REQ-005 Parameter MODE, default MODE_I2S: serial format, MODE_I2S or MODE_LJ (left-justified).
REQ-006 clk  in  1  Single system clock. All logic is synchronous to its rising edge.
REQ-007 reset  in  1  Synchronous reset, active-high.
REQ-008 enable  in  1  Run request.
REQ-009 mute  in  1  Forces transmitted samples to zero. Samples are still consumed.
REQ-010 sample_data  in  SAMPLE_W*CHANNELS  Signed samples. Channel 0 (left) is in the LSBs.
REQ-011 sample_valid  in  1  sample_data is valid.
REQ-012 sample_ready  out  1  Holding register is empty.
REQ-013 BCLK  out  1  Bit clock.
REQ-014 DAC_LR_CLK  out  1  Word select. Low = channel 0, high = channel 1.
REQ-015 DAC_DATA  out  1  Serial data, MSB first.
REQ-016 frame_done  out  1  One-cycle pulse at each frame wrap.
REQ-017 underrun  out  1  One-cycle pulse when a frame loads with no sample available.

Function
REQ-018 States SHALL be IDLE, RUN and STOP; the state SHALL be IDLE after reset.
REQ-019 IDLE->RUN SHALL occur when enable=1. The transition cycle SHALL load the frame register and set bit_cnt=0 and the divider to 0.
REQ-020 In RUN, BCLK SHALL toggle every BCLK_DIV clk cycles. fall_tick SHALL be the cycle in which BCLK goes 1->0.
REQ-021 On each fall_tick, bit_cnt SHALL increment modulo 2*SLOT_W. The frame SHALL be 2*SLOT_W BCLK periods long.
REQ-022 DAC_LR_CLK SHALL be high exactly when bit_cnt >= SLOT_W. Let p = bit_cnt mod SLOT_W.
REQ-023 In MODE_LJ, DAC_DATA SHALL be sample[SAMPLE_W-1-p] for p < SAMPLE_W, else 0.
REQ-024 In MODE_I2S, DAC_DATA SHALL be 0 for p = 0, sample[SAMPLE_W-p] for 1 <= p <= SAMPLE_W, else 0.
REQ-025 DAC_DATA and DAC_LR_CLK SHALL change only on fall_tick or on a state change.
REQ-026 When CHANNELS=1, the channel 0 sample SHALL be transmitted in both slots.
REQ-027 Frame wrap SHALL be the fall_tick at which bit_cnt goes 2*SLOT_W-1 -> 0. On wrap in RUN, frame_done=1 and the frame register SHALL load.
REQ-028 Frame load source SHALL be: the holding register if full; else sample_data if a handshake occurs in the same cycle (bypass); else zeros with underrun=1.
REQ-029 The mute value SHALL be captured at frame load. When mute=1, the loaded frame SHALL be zeros, with no underrun pulse.
REQ-030 Handshake: sample_ready SHALL equal !hold_full. A transfer SHALL occur when sample_valid && sample_ready.
REQ-031 hold_full SHALL clear in the cycle its contents are loaded into the frame register. sample_ready SHALL rise the following cycle.
REQ-032 sample_data SHALL be ignored when sample_ready=0.
REQ-033 RUN->STOP SHALL occur when enable=0. STOP SHALL continue serialising until the next wrap, then go to IDLE with no load and no frame_done.
REQ-034 STOP->RUN SHALL occur when enable=1 again, without a gap in BCLK.
REQ-035 In IDLE, BCLK, DAC_LR_CLK and DAC_DATA SHALL be 0, and hold_full SHALL be preserved.

Reset
REQ-036 While reset=1, the following SHALL hold: state IDLE; BCLK, DAC_LR_CLK, DAC_DATA, frame_done, underrun and sample_ready all 0; hold_full 0; bit_cnt 0.
REQ-037 Reset asserted mid-frame SHALL abort within one cycle, with outputs as in REQ-036. sample_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-038 The shared package audio_pkg SHALL hold the MODE_I2S/MODE_LJ enum and the derived bit_cnt width $clog2(2*SLOT_W).
REQ-039 The BCLK divider and fall_tick generation SHALL be one sub-module, audio_clk_div.
REQ-040 Elaboration SHALL fail if SLOT_W <= SAMPLE_W or if CHANNELS is not 1 or 2.

Verification (SAMPLE_W=16, SLOT_W=32, BCLK_DIV=2, CHANNELS=2; frame = 64 BCLK = 256 clk)
REQ-041 Test: MODE_I2S, sample {R=16'h8001, L=16'h1234}, enable. Required: left slot p=1..16 = 0x1234 MSB-first; right slot = 0x8001; p=0 bits are 0.
REQ-042 Test: MODE_LJ with the same sample. Required: MSB at p=0; bits 16..31 of each slot are 0; DAC_LR_CLK high for bit_cnt 32..63.
REQ-043 Test: no sample offered at a wrap. Required: underrun=1 for one cycle and a zero frame. A sample offered in the wrap cycle is bypassed with no underrun.
REQ-044 Test: enable dropped at bit_cnt=10. Required: serialisation continues to wrap (bit_cnt 63->0), then IDLE with outputs 0 and no frame_done.
REQ-045 Test: reset asserted at bit_cnt=40. Required: next cycle all outputs 0; sample_ready=1 the cycle after reset deasserts.
REQ-046 Test: mute=1 before a wrap with holding full. Required: zero frame, no underrun, holding consumed, sample_ready rises the next cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: serial format and FSM state types plus bit counter width helper for the I2S streamer
package audio_pkg;
  typedef enum logic {MODE_I2S, MODE_LJ} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
  function automatic int cnt_w(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction
endpackage

// File: rtl/i2s_audio_streamer_if.sv
// i2s_audio_streamer_if: valid/ready sample stream feeding the streamer
interface i2s_audio_streamer_if #(parameter int W = 32);
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         sample_ready;
  modport master(output sample_data, sample_valid, input sample_ready);
  modport slave(input sample_data, sample_valid, output sample_ready);
endinterface

// File: rtl/audio_clk_div.sv
// audio_clk_div: BCLK divider, held at zero while not running; fall_tick marks the 1->0 update cycle
module audio_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bclk,
  output logic fall_tick
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  logic [DW-1:0] div;
  logic          tick;
  assign tick      = div == DW'(DIV - 1);
  assign fall_tick = run && tick && bclk;
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (tick) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_audio_streamer.sv
// i2s_audio_streamer: frames buffered samples onto an I2S or left-justified serial link
module i2s_audio_streamer
  import audio_pkg::*;
#(
  parameter int    SAMPLE_W = 16,
  parameter int    SLOT_W   = 32,
  parameter int    CHANNELS = 2,
  parameter int    BCLK_DIV = 4,
  parameter mode_e MODE     = MODE_I2S
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic mute,
  i2s_audio_streamer_if.slave s_if,
  output logic BCLK,
  output logic DAC_LR_CLK,
  output logic DAC_DATA,
  output logic frame_done,
  output logic underrun
);
  localparam int CW = cnt_w(SLOT_W);
  localparam int IW = SAMPLE_W * CHANNELS;
  localparam int FW = 2 * SAMPLE_W;
  if (SLOT_W <= SAMPLE_W || (CHANNELS != 1 && CHANNELS != 2)) begin : g_bad_cfg
    $error("i2s_audio_streamer: SLOT_W must exceed SAMPLE_W and CHANNELS must be 1 or 2");
  end
  state_e            state, state_n;
  logic [CW-1:0]     bit_cnt, cnt_n, p;
  logic [FW-1:0]     frame, frame_n, fr_ld;
  logic [IW-1:0]     hold;
  logic [SAMPLE_W-1:0] slot;
  logic [SAMPLE_W:0] ext, sh;
  logic              hold_full, fall, xfer, wrap, load, lr_n, dac_n, active;
  // Mono duplicates channel 0: the top slice collapses onto the low one when IW == SAMPLE_W
  function automatic logic [FW-1:0] fmt(input logic [IW-1:0] s);
    return {s[IW-1 -: SAMPLE_W], s[SAMPLE_W-1:0]};
  endfunction
  assign s_if.sample_ready = !hold_full && !reset;
  assign xfer              = s_if.sample_valid && s_if.sample_ready;
  assign active            = state != IDLE;
  audio_clk_div #(.DIV(BCLK_DIV)) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .run      (active),
    .bclk     (BCLK),
    .fall_tick(fall)
  );
  // Serial bit is the MSB of a slot shifted left by p; the padding bit places I2S one BCLK late
  always_comb begin
    wrap    = fall && bit_cnt == CW'(2 * SLOT_W - 1);
    load    = state == IDLE ? enable : wrap && (state == RUN || enable);
    fr_ld   = (mute || !(hold_full || xfer)) ? '0 : fmt(hold_full ? hold : s_if.sample_data);
    frame_n = load ? fr_ld : frame;
    cnt_n   = wrap ? '0 : bit_cnt + CW'(fall);
    lr_n    = cnt_n >= CW'(SLOT_W);
    p       = lr_n ? cnt_n - CW'(SLOT_W) : cnt_n;
    slot    = lr_n ? frame_n[FW-1 -: SAMPLE_W] : frame_n[SAMPLE_W-1:0];
    ext     = MODE == MODE_LJ ? {slot, 1'b0} : {1'b0, slot};
    sh      = ext << p;
    dac_n   = sh[SAMPLE_W];
    state_n = enable ? RUN : state == RUN ? STOP : (state == STOP && wrap) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      frame      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      DAC_LR_CLK <= 1'b0;
      DAC_DATA   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= cnt_n;
      frame      <= frame_n;
      frame_done <= wrap && load;
      underrun   <= load && !mute && !hold_full && !xfer;
      if (load && hold_full) hold_full <= 1'b0;
      else if (xfer && !load) begin
        hold      <= s_if.sample_data;
        hold_full <= 1'b1;
      end
      if (state_n == IDLE) begin
        DAC_LR_CLK <= 1'b0;
        DAC_DATA   <= 1'b0;
      end else if (fall || load) begin
        DAC_LR_CLK <= lr_n;
        DAC_DATA   <= dac_n;
      end
    end
  end
endmodule
